// File: rtl/keypad_fifo.sv
// Matrix keypad scanner: one-hot row drive, per-frame key decode, frame-based
// debounce and a 4-entry key FIFO read through a status/data word.
module keypad_fifo #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        CLK,
  input  logic        rst_n,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        ack,
  input  logic        statusordata,
  output logic [15:0] keyout
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1) + 1;
  localparam logic [DB_W-1:0]  DB_LIMIT = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } db_state_t;

  logic [15:0]       scan_cnt_q;
  logic [1:0]        row_idx_q;
  logic              row_last_c;
  logic              frame_done_c;

  logic              col_hit_c;
  logic [1:0]        col_idx_c;
  logic              acc_hit_q;
  logic [CODE_W-1:0] acc_code_q;
  logic              frame_hit_c;
  logic [CODE_W-1:0] frame_code_c;

  db_state_t         state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              push_c;
  logic [CODE_W-1:0] push_code_c;

  logic              ack_q;
  logic              pop_req_q;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              do_pop_c, do_push_c, drop_c;

  // Row scan timing: each row is driven for SCAN_DIV cycles, sampled on its last cycle
  always_comb begin
    row_last_c   = (scan_cnt_q == (SCAN_DIV - 16'd1));
    frame_done_c = row_last_c && (row_idx_q == 2'd3);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= 16'd0;
      row_idx_q  <= 2'd0;
      rowwrite   <= 4'b1110;
    end else if (row_last_c) begin
      scan_cnt_q <= 16'd0;
      row_idx_q  <= row_idx_q + 2'd1;
      rowwrite   <= {rowwrite[2:0], rowwrite[3]};
    end else begin
      scan_cnt_q <= scan_cnt_q + 16'd1;
    end
  end

  // Lowest active column of the current row; scanning downward lets the lowest win
  always_comb begin
    col_hit_c = 1'b0;
    col_idx_c = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!colread[c]) begin
        col_hit_c = 1'b1;
        col_idx_c = 2'(c);
      end
    end
  end

  // Rows are visited in ascending order, so the first hit of a frame is its lowest code
  always_comb begin
    frame_hit_c  = acc_hit_q | col_hit_c;
    frame_code_c = acc_hit_q ? acc_code_q : {row_idx_q, col_idx_c};
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit_q  <= 1'b0;
      acc_code_q <= '0;
    end else if (row_last_c) begin
      if (row_idx_q == 2'd3) begin
        acc_hit_q <= 1'b0;
      end else if (!acc_hit_q && col_hit_c) begin
        acc_hit_q  <= 1'b1;
        acc_code_q <= {row_idx_q, col_idx_c};
      end
    end
  end

  // Debounce state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Debounce next-state: evaluated once per completed frame
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    db_cnt_d    = db_cnt_q;
    push_c      = 1'b0;
    push_code_c = cand_q;
    if (frame_done_c) begin
      case (state_q)
        IDLE: begin
          if (frame_hit_c) begin
            cand_d   = frame_code_c;
            db_cnt_d = DB_W'(1);
            if (DB_W'(1) >= DB_LIMIT) begin
              push_c      = 1'b1;
              push_code_c = frame_code_c;
              state_d     = HELD;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (frame_hit_c && (frame_code_c == cand_q)) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
            if (db_cnt_d >= DB_LIMIT) begin
              push_c  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!frame_hit_c) begin
            db_cnt_d = DB_W'(1);
            state_d  = (DB_W'(1) >= DB_LIMIT) ? IDLE : RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (frame_hit_c) begin
            state_d = HELD;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
            if (db_cnt_d >= DB_LIMIT) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still takes a push when the same cycle pops
  always_comb begin
    do_pop_c  = pop_req_q && (count_q != 3'd0);
    do_push_c = push_c && ((count_q != FULL_CNT) || do_pop_c);
    drop_c    = push_c && !do_push_c;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      pop_req_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ack_q     <= ack;
      pop_req_q <= ack & ~ack_q;
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_code_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (do_pop_c) begin
        ovf_q <= 1'b0;
      end else if (drop_c) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Bus word straight from registered FIFO state
  always_comb begin
    keyout = 16'h0000;
    if (statusordata) begin
      keyout = {ovf_q, 8'd0, count_q, 3'd0, (count_q != 3'd0)};
    end else if (count_q != 3'd0) begin
      keyout = {12'd0, mem_q[rd_ptr_q]};
    end
  end

endmodule

// File: tb/tb_keypad_fifo.sv
// Bench for keypad_fifo: a key-matrix model drives colread from rowwrite, and a
// queue of expected key codes is compared against the data word on every pop.
module tb_keypad_fifo;

  localparam logic [15:0] SDIV  = 16'd4;
  localparam int unsigned FRAME = 16;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        ack = 1'b0;
  logic        statusordata = 1'b0;
  logic [15:0] keyout;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  bit         m_ovf = 1'b0;

  keypad_fifo #(.SCAN_DIV(SDIV), .DEBOUNCE(3)) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .rowwrite(rowwrite),
    .colread(colread),
    .ack(ack),
    .statusordata(statusordata),
    .keyout(keyout)
  );

  always #5 CLK = ~CLK;

  // Key matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rowwrite[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4 + c]) colread[c] = 1'b0;
        end
      end
    end
  end

  function automatic logic [15:0] status_word(bit o, int unsigned n);
    return {o, 8'd0, 3'(n), 3'd0, (n != 0)};
  endfunction

  function automatic logic [15:0] head_word();
    logic [3:0] h;
    if (exp_q.size() == 0) return 16'h0000;
    h = exp_q[0];
    return {12'd0, h};
  endfunction

  task automatic model_push(input int code);
    if (exp_q.size() < 4) exp_q.push_back(4'(code));
    else m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_ovf = 1'b0;
    end
  endtask

  // Leaves the bench at the negedge right after row 0 of a new frame starts
  task automatic align_frame();
    int n;
    n = 0;
    while (rowwrite !== 4'b0111 && n < 100) begin @(negedge CLK); n++; end
    while (rowwrite !== 4'b1110 && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL align_frame timeout rowwrite=%b", rowwrite);
    end
  endtask

  task automatic hold(input logic [15:0] mask, input int frames);
    align_frame();
    keys = mask;
    repeat (frames * FRAME) @(negedge CLK);
  endtask

  task automatic press_key(input int code);
    hold(16'(1) << code, 3);
    model_push(code);
    hold(16'h0000, 3);
  endtask

  task automatic ack_pulse(input int cycles);
    @(negedge CLK);
    ack = 1'b1;
    repeat (cycles) @(negedge CLK);
    ack = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    total++;
    if (rowwrite !== 4'b1110) begin bad++; $display("FAIL reset_row got=%b exp=1110", rowwrite); end
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", keyout); end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", keyout); end
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_single_key();
    align_frame();
    keys = 16'h0040;
    repeat (2 * FRAME) @(negedge CLK);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL early_push got=%h exp=0000", keyout); end
    repeat (FRAME) @(negedge CLK);
    model_push(6);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== status_word(m_ovf, exp_q.size())) begin
      bad++; $display("FAIL single_status got=%h exp=%h", keyout, status_word(m_ovf, exp_q.size()));
    end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== 16'h0006) begin bad++; $display("FAIL single_data got=%h exp=0006", keyout); end
    repeat (17 * FRAME) @(negedge CLK);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0011) begin bad++; $display("FAIL no_repeat got=%h exp=0011", keyout); end
    hold(16'h0000, 3);
    press_key(9);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0021) begin bad++; $display("FAIL two_keys got=%h exp=0021", keyout); end
    for (int i = 0; i < 2; i++) begin
      statusordata = 1'b0; #1;
      total++;
      if (keyout !== head_word()) begin bad++; $display("FAIL read_%0d got=%h exp=%h", i, keyout, head_word()); end
      model_pop();
      ack_pulse(1);
    end
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL drained got=%h exp=0000", keyout); end
  endtask

  task automatic test_overflow();
    for (int c = 1; c <= 5; c++) press_key(c);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h8041 || keyout !== status_word(m_ovf, exp_q.size())) begin
      bad++; $display("FAIL ovf_status got=%h exp=8041", keyout);
    end
    for (int i = 0; i < 4; i++) begin
      statusordata = 1'b0; #1;
      total++;
      if (keyout !== head_word()) begin bad++; $display("FAIL ovf_read_%0d got=%h exp=%h", i, keyout, head_word()); end
      model_pop();
      ack_pulse(1);
      if (i == 0) begin
        statusordata = 1'b1; #1;
        total++;
        if (keyout !== status_word(m_ovf, exp_q.size())) begin
          bad++; $display("FAIL ovf_clear got=%h exp=%h", keyout, status_word(m_ovf, exp_q.size()));
        end
      end
    end
  endtask

  task automatic test_ack_held();
    press_key(10);
    press_key(11);
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== head_word()) begin bad++; $display("FAIL held_head got=%h exp=%h", keyout, head_word()); end
    model_pop();
    ack_pulse(10);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0011) begin bad++; $display("FAIL ack_held_once got=%h exp=0011", keyout); end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== head_word()) begin bad++; $display("FAIL held_next got=%h exp=%h", keyout, head_word()); end
    model_pop();
    ack_pulse(1);
    ack_pulse(1);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL empty_pop_status got=%h exp=0000", keyout); end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL empty_pop_data got=%h exp=0000", keyout); end
  endtask

  task automatic test_priority_glitch();
    hold(16'h1008, 3);
    model_push(3);
    hold(16'h0000, 3);
    hold(16'h0080, 1);
    hold(16'h0000, 3);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== status_word(m_ovf, exp_q.size())) begin
      bad++; $display("FAIL glitch_status got=%h exp=%h", keyout, status_word(m_ovf, exp_q.size()));
    end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== 16'h0003) begin bad++; $display("FAIL priority_data got=%h exp=0003", keyout); end
    model_pop();
    ack_pulse(1);
  endtask

  // Pop lands on the same edge as the push from a full FIFO
  task automatic test_back_to_back();
    for (int c = 1; c <= 4; c++) press_key(c);
    align_frame();
    keys = 16'h0100;
    repeat (3 * FRAME - 2) @(negedge CLK);
    ack = 1'b1;
    @(negedge CLK);
    ack = 1'b0;
    repeat (2) @(negedge CLK);
    model_pop();
    model_push(8);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== status_word(m_ovf, exp_q.size())) begin
      bad++; $display("FAIL full_pushpop got=%h exp=%h", keyout, status_word(m_ovf, exp_q.size()));
    end
    hold(16'h0000, 3);
    for (int i = 0; i < 4; i++) begin
      statusordata = 1'b0; #1;
      total++;
      if (keyout !== head_word()) begin bad++; $display("FAIL b2b_read_%0d got=%h exp=%h", i, keyout, head_word()); end
      model_pop();
      ack_pulse(1);
    end
  endtask

  task automatic test_reset_mid_debounce();
    press_key(2);
    press_key(5);
    press_key(13);
    align_frame();
    keys = 16'h4000;
    repeat (FRAME + 6) @(negedge CLK);
    rst_n = 1'b0;
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL midrst_status got=%h exp=0000", keyout); end
    statusordata = 1'b0; #1;
    total++;
    if (keyout !== 16'h0000) begin bad++; $display("FAIL midrst_data got=%h exp=0000", keyout); end
    total++;
    if (rowwrite !== 4'b1110) begin bad++; $display("FAIL midrst_row got=%b exp=1110", rowwrite); end
    keys = 16'h0000;
    #1 rst_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    repeat (5 * FRAME) @(negedge CLK);
    statusordata = 1'b1; #1;
    total++;
    if (keyout !== status_word(m_ovf, exp_q.size())) begin
      bad++; $display("FAIL midrst_nopush got=%h exp=%h", keyout, status_word(m_ovf, exp_q.size()));
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_overflow();
    test_ack_held();
    test_priority_glitch();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_fifo.md
KEYPAD_FIFO -- requirements
Module: keypad_fifo

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 16'd50000, setting the clock cycles spent driving each keypad row.
REQ-002 The module SHALL have parameter DEBOUNCE, default 3, setting the consecutive identical scan frames required to accept a press or release.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port rowwrite, output, 4 bits: row drive, one-hot active-low.
REQ-006 Port colread, input, 4 bits: column sense, active-low, pulled up externally.
REQ-007 Port ack, input, 1 bit: pop request from the bus; it may be held high for many cycles.
REQ-008 Port statusordata, input, 1 bit: 1 selects the status word on keyout, 0 selects the data word.
REQ-009 Port keyout, output, 16 bits: the status or data word, driven combinationally from registered state.

Function
REQ-010 The row sequence SHALL be 4'b1110, 4'b1101, 4'b1011, 4'b0111, then repeat; each row is held for SCAN_DIV cycles.
REQ-011 colread SHALL be sampled in the last cycle of each row period; one pass over all 4 rows forms one frame.
REQ-012 The frame key code SHALL be row*4+col (row 0 = rowwrite bit0 low, col 0 = colread bit0); if several keys are down, the lowest code wins; if no key is down, the frame is "none".
REQ-013 The debounce state machine SHALL have states IDLE, PRESS_CHK, HELD and RELEASE_CHK.
- IDLE -> PRESS_CHK: frame code != none; the candidate is latched and the counter set to 1.
- PRESS_CHK: a frame equal to the candidate increments the counter; a different frame returns to IDLE; reaching DEBOUNCE pushes the candidate and goes to HELD.
- HELD -> RELEASE_CHK: frame is none.
- RELEASE_CHK: DEBOUNCE consecutive none frames -> IDLE; any key frame -> HELD.
REQ-014 Exactly one push SHALL occur per accepted press; a held key SHALL produce no auto-repeat.
REQ-015 The FIFO SHALL be 4 entries of 4 bits, with 2-bit read/write pointers that wrap from 3 to 0 and a 3-bit count from 0 to 4.
REQ-016 A push while count==4 SHALL be dropped, with contents unchanged and sticky flag ovf set to 1.
REQ-017 A pop SHALL occur on the cycle after a registered rising edge of ack (ack 0 -> 1); ack held high SHALL pop only once.
REQ-018 A pop while count==0 SHALL have no effect.
REQ-019 A push and pop in the same cycle with 0 < count < 4 SHALL both occur, leaving count unchanged.
REQ-020 A simultaneous push and pop when count==4 SHALL accept the push, with no ovf.
REQ-021 ovf SHALL clear on any pop of a non-empty FIFO.
REQ-022 Status word (statusordata=1): bit15=ovf, bits6:4=count, bit0=(count!=0), all other bits 0.
REQ-023 Data word (statusordata=0): {12'b0, head code} when count!=0, else 16'h0000.
REQ-024 keyout SHALL reflect the new head in the same cycle the pop updates the read pointer.

Reset
REQ-025 While rst_n=0: rowwrite=4'b1110, the scan counter is 0, the state machine is IDLE, pointers, count and ovf are 0, and the ack edge register is 0.
REQ-026 With rst_n=0, keyout SHALL read 16'h0000 for either value of statusordata.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard all pending and buffered keys; scanning restarts at row 0 on the first edge after rst_n rises.

Verification
REQ-028 Key code 6 (row1/col2) held for 3 frames, with SCAN_DIV=4 -> push after frame 3; status=16'h0011; data=16'h0006.
REQ-029 Key code 6 held for 20 frames -> exactly one entry; release for 3 frames then press code 9 -> status count=2; the data reads 6 and then 9 across two ack pulses.
REQ-030 Five debounced presses (codes 1,2,3,4,5) with no pops -> status=16'h8041; reads return 1,2,3,4; ovf=0 after the first pop.
REQ-031 ack held high for 10 cycles with count=2 -> count becomes 1, not 0; ack with count=0 -> count stays 0 and data=16'h0000.
REQ-032 Keys 3 and 12 pressed together -> code 3 is pushed; a 1-frame glitch on key 7 -> no push.
REQ-033 rst_n pulsed low for 1 cycle between CLK edges during PRESS_CHK with count=3 -> keyout=16'h0000 immediately; rowwrite=4'b1110; no later push of the interrupted key.
